// File: rtl/song_sequencer.sv
// Autoplay source for the piano: plays a fixed Ode to Joy phrase from an internal ROM
// as a one-hot switch-equivalent vector, with start/stop/loop control and busy/done status.
module song_sequencer #(
    parameter int unsigned UNIT_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 2_500_000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [7:0] sw_out,
    output logic [3:0] note_idx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW       = $clog2(4 * UNIT_TICKS);
    localparam logic [3:0]  LAST_IDX = 4'd14;

    localparam logic [7:0] N_C4 = 8'b1000_0000;
    localparam logic [7:0] N_D  = 8'b0100_0000;
    localparam logic [7:0] N_E  = 8'b0010_0000;
    localparam logic [7:0] N_F  = 8'b0001_0000;
    localparam logic [7:0] N_G  = 8'b0000_1000;

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    // ROM entry: {one-hot note, duration in half-beat units}
    function automatic logic [10:0] rom_entry(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd6, 4'd11: rom_entry = {N_E,  3'd2};
            4'd2, 4'd5:              rom_entry = {N_F,  3'd2};
            4'd3, 4'd4:              rom_entry = {N_G,  3'd2};
            4'd7, 4'd10:             rom_entry = {N_D,  3'd2};
            4'd8, 4'd9:              rom_entry = {N_C4, 3'd2};
            4'd12:                   rom_entry = {N_E,  3'd3};
            4'd13:                   rom_entry = {N_D,  3'd1};
            4'd14:                   rom_entry = {N_D,  3'd4};
            default:                 rom_entry = {8'h00, 3'd1};
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [7:0]     sw_q, sw_d;
    logic [3:0]     idx_q, idx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           load_note;
    logic [3:0]     load_idx;
    logic [10:0]    entry;

    assign entry = rom_entry(load_idx);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sw_d      = sw_q;
        idx_d     = idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load_note = 1'b0;
        load_idx  = '0;

        case (state_q)
            IDLE: begin
                sw_d   = '0;
                idx_d  = '0;
                busy_d = 1'b0;
                if (start && !stop) begin
                    load_note = 1'b1;
                end
            end
            NOTE: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sw_d    = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CW'(GAP_TICKS - 1);
                    sw_d    = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == '0) begin
                    if (idx_q < LAST_IDX) begin
                        load_note = 1'b1;
                        load_idx  = idx_q + 4'd1;
                    end else if (loop_en) begin
                        load_note = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sw_d    = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        // Audible part of a note is dur*UNIT_TICKS-GAP_TICKS cycles; the gap follows.
        if (load_note) begin
            state_d = NOTE;
            idx_d   = load_idx;
            sw_d    = entry[10:3];
            busy_d  = 1'b1;
            cnt_d   = CW'(entry[2:0]) * CW'(UNIT_TICKS) - CW'(GAP_TICKS) - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sw_q    <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sw_out   = sw_q;
    assign note_idx = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: stimulus pushes expected output-change events,
// a monitor pops and compares them whenever the DUT outputs change.
module tb_song_sequencer;

    localparam int unsigned UT = 10;
    localparam int unsigned GT = 2;
    localparam int unsigned PH = 32 * UT;

    localparam logic [7:0] C4 = 8'h80;
    localparam logic [7:0] D  = 8'h40;
    localparam logic [7:0] E  = 8'h20;
    localparam logic [7:0] F  = 8'h10;
    localparam logic [7:0] G  = 8'h08;

    logic       CLK     = 1'b0;
    logic       RESET_N = 1'b1;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] sw_out;
    logic [3:0] note_idx;
    logic       busy;
    logic       done;

    song_sequencer #(.UNIT_TICKS(UT), .GAP_TICKS(GT)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .sw_out   (sw_out),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int unsigned t;
        logic [7:0]  sw;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;

    logic [7:0]  tn [15] = '{E, E, F, G, G, F, E, D, C4, C4, D, E, E, D, D};
    int unsigned td [15] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4};

    task automatic push_ev(input int unsigned t, input logic [7:0] sw, input logic [3:0] idx,
                           input logic b, input logic dn);
        ev_t e;
        e.t = t; e.sw = sw; e.idx = idx; e.busy = b; e.done = dn;
        exp_q.push_back(e);
    endtask

    // Note-on and note-off events for ROM indices first..last of a pass starting at base.
    task automatic push_notes(input int unsigned base, input int first, input int last);
        int unsigned t;
        t = base;
        for (int i = 0; i < first; i++) t += td[i] * UT;
        for (int i = first; i <= last; i++) begin
            push_ev(t, tn[i], 4'(i), 1'b1, 1'b0);
            push_ev(t + td[i] * UT - GT, 8'h00, 4'(i), 1'b1, 1'b0);
            t += td[i] * UT;
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic wait_drain(input int max, input string name);
        for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: %0d events still pending, required 0 (next at cyc %0d)",
                     name, exp_q.size(), exp_q[0].t);
            exp_q.delete();
        end
    endtask

    task automatic chk_outs(input string name, input logic [7:0] sw, input logic [3:0] idx,
                            input logic b, input logic dn);
        n_checks++;
        if (sw_out !== sw || note_idx !== idx || busy !== b || done !== dn) begin
            n_fail++;
            $display("FAIL %s: got sw=%b idx=%0d busy=%b done=%b, required sw=%b idx=%0d busy=%b done=%b",
                     name, sw_out, note_idx, busy, done, sw, idx, b, dn);
        end
    endtask

    // Monitor: one-hot invariant every cycle, scoreboard compare on every output change.
    initial begin
        ev_t        e;
        logic [7:0] p_sw;
        logic [3:0] p_idx;
        logic       p_busy, p_done;
        p_sw = '0; p_idx = '0; p_busy = 1'b0; p_done = 1'b0;
        forever begin
            @(negedge CLK);
            n_checks++;
            if ($countones(sw_out) > 1) begin
                n_fail++;
                $display("FAIL onehot at cyc %0d: sw_out=%b, required one-hot or zero", cyc, sw_out);
            end
            if (mon_en && {sw_out, note_idx, busy, done} !== {p_sw, p_idx, p_busy, p_done}) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected change at cyc %0d: sw=%b idx=%0d busy=%b done=%b, required no change",
                             cyc, sw_out, note_idx, busy, done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != cyc || e.sw !== sw_out || e.idx !== note_idx ||
                        e.busy !== busy || e.done !== done) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d sw=%b idx=%0d busy=%b done=%b, required cyc=%0d sw=%b idx=%0d busy=%b done=%b",
                                 cyc, sw_out, note_idx, busy, done, e.t, e.sw, e.idx, e.busy, e.done);
                    end
                end
            end
            p_sw = sw_out; p_idx = note_idx; p_busy = busy; p_done = done;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk_outs("reset_state", 8'h00, 4'd0, 1'b0, 1'b0);
        RESET_N = 1'b1;
        @(negedge CLK);
        mon_en = 1'b1;

        // Single start pulse, full phrase, start re-pulsed mid-playback, done at +320.
        @(negedge CLK);
        start = 1'b1;
        s = cyc + 1;
        push_notes(s, 0, 14);
        push_ev(s + PH, 8'h00, 4'd0, 1'b0, 1'b1);
        push_ev(s + PH + 1, 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge CLK);
        start = 1'b0;
        wait_cyc(s + 55);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_drain(PH + 20, "phrase");

        // Loop across the end, then stop during note 5 of the second pass.
        @(negedge CLK);
        loop_en = 1'b1;
        start   = 1'b1;
        s = cyc + 1;
        push_notes(s, 0, 14);
        push_notes(s + PH, 0, 4);
        push_ev(s + PH + 100, F, 4'd5, 1'b1, 1'b0);
        push_ev(s + PH + 106, 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge CLK);
        start = 1'b0;
        wait_cyc(s + PH + 5);
        loop_en = 1'b0;
        wait_cyc(s + PH + 105);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        wait_drain(20, "loop_stop");

        // stop together with start in IDLE must keep the sequencer idle.
        @(negedge CLK);
        stop  = 1'b1;
        start = 1'b1;
        repeat (4) @(negedge CLK);
        chk_outs("stop_start_idle", 8'h00, 4'd0, 1'b0, 1'b0);
        stop  = 1'b0;
        start = 1'b0;

        // Later start restarts at index 0; stop during note 2.
        @(negedge CLK);
        start = 1'b1;
        s = cyc + 1;
        push_notes(s, 0, 1);
        push_ev(s + 40, F, 4'd2, 1'b1, 1'b0);
        push_ev(s + 46, 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge CLK);
        start = 1'b0;
        wait_cyc(s + 45);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        wait_drain(20, "restart_stop");

        // start held high: restart the cycle right after done.
        @(negedge CLK);
        start = 1'b1;
        s = cyc + 1;
        push_notes(s, 0, 14);
        push_ev(s + PH, 8'h00, 4'd0, 1'b0, 1'b1);
        push_ev(s + PH + 1, E, 4'd0, 1'b1, 1'b0);
        push_ev(s + PH + 6, 8'h00, 4'd0, 1'b0, 1'b0);
        wait_cyc(s + PH + 1);
        start = 1'b0;
        wait_cyc(s + PH + 5);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        wait_drain(20, "held_start");

        // Asynchronous reset in the middle of a note.
        @(negedge CLK);
        start = 1'b1;
        s = cyc + 1;
        push_ev(s, E, 4'd0, 1'b1, 1'b0);
        @(negedge CLK);
        start = 1'b0;
        wait_drain(5, "pre_reset");
        mon_en = 1'b0;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1;
        chk_outs("pre_async_reset", E, 4'd0, 1'b1, 1'b0);
        #1;
        RESET_N = 1'b0;
        #1;
        chk_outs("async_reset", 8'h00, 4'd0, 1'b0, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Autoplay source that sits directly upstream of the piano top level.
- Steps through a fixed Ode to Joy phrase stored in an internal ROM and drives an 8-bit switch-equivalent vector.
- That vector is muxed with the physical switches in front of the piano's note-priority logic, so the tone generator, note extractor and display need no changes.
- Provides start/stop/loop control, per-note durations, an inter-note silence gap, and busy/done status.

Parameters:
- UNIT_TICKS, 25_000_000: clock cycles per duration unit (one half-beat); minimum 4.
- GAP_TICKS, 2_500_000: silent cycles at the end of every note (articulation); must satisfy 1 <= GAP_TICKS < UNIT_TICKS.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- start  in  1  level; sampled high in IDLE begins playback at ROM index 0
- stop  in  1  level; sampled high aborts playback from any state
- loop_en  in  1  when high at end of last note, restart at index 0 instead of finishing
- sw_out  out  8  one-hot note vector; bit7=C4, bit6=D, bit5=E, bit4=F, bit3=G, bit2=A, bit1=B, bit0=C5; all-zero = silence
- note_idx  out  4  ROM index currently playing (0..14)
- busy  out  1  high in NOTE or GAP
- done  out  1  one-cycle pulse when the phrase completes without looping

Behaviour:
- Reset, asynchronous on RESET_N low: state=IDLE, sw_out=0, note_idx=0, busy=0, done=0, counter=0. Takes effect mid-note with no drain.
- ROM: 15 combinational entries {note, dur} in units. The sequence is:
  - E2 E2 F2 G2 G2 F2 E2 D2 C2 C2 D2 E2 E3 D1 D4
  - Total 32 units.
- States:
  - IDLE: sw_out=0, busy=0. If start=1 and stop=0, go to NOTE with note_idx=0 and counter loaded with dur*UNIT_TICKS-GAP_TICKS-1.
  - NOTE: sw_out = one-hot of ROM[note_idx]. Counter decrements each cycle. At counter==0, go to GAP with counter=GAP_TICKS-1.
  - GAP: sw_out=0. At counter==0:
    - if note_idx<14: note_idx+1, go to NOTE with reloaded counter;
    - else if loop_en=1: note_idx=0, go to NOTE;
    - else go to IDLE with done=1 for exactly one cycle and note_idx=0.
- Latency: start sampled at edge k puts the first note on sw_out from edge k+1.
- Note timing: each note is audible for exactly dur*UNIT_TICKS-GAP_TICKS cycles, followed by exactly GAP_TICKS zero cycles.
- Note-to-note period: exactly dur*UNIT_TICKS cycles, with no extra bubbles.
- stop: sampled high in NOTE or GAP, the next edge gives IDLE, sw_out=0, note_idx=0, done=0. Stop has priority over start and over end-of-phrase.
- start while busy is ignored. start held high continuously in IDLE restarts immediately after done.
- loop_en is only sampled at the GAP-to-next decision of index 14.
- Counter width: ceil(log2(4*UNIT_TICKS)). All products are computed at that width; no overflow is allowed.
- sw_out is always one-hot or zero. It is registered and never glitches.

Test Plan (UNIT_TICKS=10, GAP_TICKS=2):
1. Reset → sw_out=0, busy=0, note_idx=0, done=0. Assert RESET_N=0 mid-NOTE → all outputs 0 asynchronously, before the next edge.
2. One-cycle start pulse:
   - sw_out=8'b0010_0000 (E) for 18 cycles starting one cycle after start, then 0 for 2 cycles, then E again for 18 cycles.
   - note_idx increments on the edge where the gap ends.
3. Full phrase with loop_en=0:
   - index 12 is E high for 28 cycles;
   - index 13 is D (8'b0100_0000) for 8 cycles;
   - index 14 is D for 38 cycles;
   - done pulses once exactly 320 cycles after playback began;
   - busy falls the same cycle done rises.
4. loop_en=1 across the end → after the final 2-cycle gap, sw_out=E with note_idx=0; done stays 0 and busy stays 1.
5. stop asserted together with start in IDLE → stays IDLE. stop during note 5 → sw_out=0 and note_idx=0 the next cycle; a later start restarts at index 0.
6. start re-pulsed during playback → no timing change. Check the sw_out one-hot invariant every cycle throughout.
